// File: rtl/bnn_pkg.sv
// Shared BNN opcode constants and instruction-fetch state encoding.
// Pure declarations; no logic, no latency, no backpressure.
package bnn_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;

  localparam logic [OPC_MSB-OPC_LSB:0] OP_END  = 5'b11111;
  localparam logic [OPC_MSB-OPC_LSB:0] OP_NULL = 5'b00000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic is_end_op(input logic [OPC_MSB-OPC_LSB:0] opc);
    return opc == OP_END;
  endfunction

endpackage

// File: rtl/bnn_ifetch_fifo.sv
// Prefetch FIFO of {pc, inst}; head is a registered read, one-cycle push-to-head latency.
// Flush beats push/pop; pushes while full are dropped, so the caller must reserve space before issuing reads.
module bnn_ifetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bnn_inst_fetch.sv
// Instruction fetch for the BPU controller: start/redirect in cycle N gives inst_valid in N+1, one inst/cycle.
// Reads stop while buffered+inflight reaches DEPTH; IFETCH_PERF_EN adds the perf_stall_cnt stall counter.
module bnn_inst_fetch
  import bnn_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int INST_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [INST_W-1:0] sram_rdata,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
`ifdef IFETCH_PERF_EN
  output logic [31:0]       perf_stall_cnt,
`endif
  output logic              busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = ADDR_W + INST_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic [FW-1:0]     fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_full;

  logic              redirect_act;
  logic [INST_W-1:0] head_inst;
  logic [ADDR_W-1:0] head_pc;
  logic              head_vld;
  logic              pop, pop_end, rdata_end, push;
  logic [CW:0]       occ;

  bnn_ifetch_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_dat ({inflight_pc_q, sram_rdata}),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    sram_en       = 1'b0;
    sram_addr     = '0;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;

    // With an empty FIFO the returning SRAM word is the head, which is what
    // gives start/redirect-to-valid a single cycle despite the SRAM latency.
    redirect_act = redirect && (state_q != IDLE);
    head_inst    = fifo_empty ? sram_rdata : fifo_head[INST_W-1:0];
    head_pc      = fifo_empty ? inflight_pc_q : fifo_head[FW-1:INST_W];
    head_vld     = !fifo_empty || inflight_q;
    inst_valid   = head_vld && !redirect_act;
    inst         = inst_valid ? head_inst : '0;
    inst_pc      = inst_valid ? head_pc : '0;

    pop       = inst_valid && inst_ready;
    pop_end   = pop && is_end_op(head_inst[OPC_MSB:OPC_LSB]);
    rdata_end = inflight_q && is_end_op(sram_rdata[OPC_MSB:OPC_LSB]);
    push      = inflight_q && !(pop && fifo_empty);
    occ       = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sram_en       = 1'b1;
          sram_addr     = start_pc;
          fetch_pc_d    = start_pc + ADDR_W'(1);
          inflight_d    = 1'b1;
          inflight_pc_d = start_pc;
          state_d       = FETCH;
        end
      end
      FETCH, DRAIN: begin
        if (redirect) begin
          fifo_flush    = 1'b1;
          sram_en       = 1'b1;
          sram_addr     = redirect_pc;
          fetch_pc_d    = redirect_pc + ADDR_W'(1);
          inflight_d    = 1'b1;
          inflight_pc_d = redirect_pc;
          state_d       = FETCH;
        end else begin
          fifo_push = push;
          fifo_pop  = pop && !fifo_empty;
          if (pop_end) begin
            fifo_flush = 1'b1;
            state_d    = IDLE;
          end else if (push && rdata_end) begin
            state_d = DRAIN;
          end else if (state_q == FETCH && !rdata_end && !fifo_full &&
                       occ < (CW+1)'(DEPTH)) begin
            // Same-cycle pops are deliberately not credited to keep this path short.
            sram_en       = 1'b1;
            sram_addr     = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  // The redirect cycle itself is not a stall: the controller caused it.
  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (state_q == IDLE && start) begin
      perf_stall_cnt_d = '0;
    end else if (busy && !inst_valid && !redirect && perf_stall_cnt_q != '1) begin
      perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_q <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_bnn_inst_fetch.sv
// Scoreboard bench for bnn_inst_fetch: expected {pc,inst} streams come from walking a memory image.
module tb_bnn_inst_fetch;
  import bnn_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, redirect, inst_ready;
  logic [15:0] start_pc, redirect_pc;
  logic        sram_en;
  logic [15:0] sram_addr;
  logic [15:0] sram_rdata = '0;
  logic [15:0] inst, inst_pc;
  logic        inst_valid, busy;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  bnn_inst_fetch #(.ADDR_W(16), .INST_W(16), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_pc    (start_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .sram_en     (sram_en),
    .sram_addr   (sram_addr),
    .sram_rdata  (sram_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
`ifdef IFETCH_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .busy        (busy)
  );

  logic [15:0] mem [65536];
  always @(posedge clk) if (sram_en) sram_rdata <= mem[sram_addr];

  logic [31:0] exp_q [$];
  bit          model_busy = 1'b0;
  bit          start_acc  = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rand_inst();
    logic [4:0] op;
    op = 5'($urandom_range(0, 30));
    return {op, 11'($urandom)};
  endfunction

  task automatic load_prog(input logic [15:0] base, input int len);
    for (int i = 0; i < len; i++) mem[16'(base + 16'(i))] = rand_inst();
    mem[16'(base + 16'(len))] = {OP_END, 11'($urandom)};
  endtask

  // Expected stream: sequential words from pc up to and including the first END.
  task automatic push_prog(input logic [15:0] pc);
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({pc, mem[pc]});
      if (mem[pc][15:11] == OP_END) break;
      pc = pc + 16'd1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_acc = 1'b0;
    redirect  = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic issue_start(input logic [15:0] pc);
    start     = 1'b1;
    start_pc  = pc;
    start_acc = !model_busy;
    if (!model_busy) begin
      exp_q.delete();
      push_prog(pc);
      model_busy = 1'b1;
    end
  endtask

  task automatic issue_redirect(input logic [15:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    if (model_busy) begin
      exp_q.delete();
      push_prog(pc);
    end
  endtask

  task automatic wait_done(input int budget, input int rdy_pct, input int rd_pct,
                           input logic [15:0] lo, input int span);
    for (int n = 0; n < budget && model_busy; n++) begin
      inst_ready = ($urandom_range(0, 99) < rdy_pct);
      if (model_busy && $urandom_range(0, 99) < rd_pct)
        issue_redirect(16'(lo + 16'($urandom_range(0, span))));
      @(negedge clk);
      cyc();
    end
  endtask

  // Monitor: compares the presented head with the scoreboard and retires it on a pop.
  always @(negedge clk) begin
    logic [31:0] hd;
    if (!rst) begin
      chk("busy", {31'd0, busy}, {31'd0, model_busy && !start_acc});
      if (redirect && model_busy) begin
        chk("redirect_vld", {31'd0, inst_valid}, 32'd0);
      end else if (inst_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vld", {16'd0, inst_pc}, 32'hFFFF_FFFF);
        end else begin
          hd = exp_q[0];
          chk("inst_pc", {16'd0, inst_pc}, {16'd0, hd[31:16]});
          chk("inst", {16'd0, inst}, {16'd0, hd[15:0]});
          if (inst_ready) begin
            void'(exp_q.pop_front());
            if (hd[15:11] == OP_END) model_busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          en_cnt, gaps;
    bit          seen13;
    logic [15:0] wrap_pc [3];
    logic [15:0] base;
    int          len;

    wrap_pc[0] = 16'hFFFE; wrap_pc[1] = 16'hFFFF; wrap_pc[2] = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = {OP_NULL, 11'h7FF};
    rst = 1'b1; start = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
    start_pc = '0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_sram_en", {31'd0, sram_en}, 32'd0);
    chk("rst_sram_addr", {16'd0, sram_addr}, 32'd0);
    chk("rst_inst", {16'd0, inst}, 32'd0);
    chk("rst_inst_pc", {16'd0, inst_pc}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    cyc();

    // Four-instruction program, consumer always ready.
    for (int i = 0; i < 3; i++) mem[16'h10 + i] = {OP_NULL, 11'(i)};
    mem[16'h13] = {OP_END, 11'h0};
    inst_ready = 1'b1;
    issue_start(16'h0010);
    en_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      en_cnt += int'(sram_en);
      if (c >= 1 && c <= 4) begin
        chk("t1_vld", {31'd0, inst_valid}, 32'd1);
        chk("t1_pc", {16'd0, inst_pc}, 32'(16'h10 + c - 1));
      end
`ifdef IFETCH_PERF_EN
      if (c == 1) chk("t1_perf", perf_stall_cnt, 32'd0);
`endif
      if (c == 5) chk("t1_busy5", {31'd0, busy}, 32'd0);
      cyc();
    end
    chk("t1_reads", 32'(en_cnt), 32'd4);

    // Backpressure: six NULLs + END with the consumer stalled; a start mid-run is ignored.
    for (int i = 0; i < 6; i++) mem[16'h10 + i] = {OP_NULL, 11'(i + 8)};
    mem[16'h16] = {OP_END, 11'h1};
    inst_ready = 1'b0;
    issue_start(16'h0010);
    en_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) issue_start(16'h0040);
      @(negedge clk);
      en_cnt += int'(sram_en);
      if (c == 9) chk("t2_en_held", {31'd0, sram_en}, 32'd0);
      cyc();
    end
    chk("t2_reads", 32'(en_cnt), 32'd4);
    inst_ready = 1'b1;
    gaps = 0;
    for (int c = 0; c < 40 && model_busy; c++) begin
      @(negedge clk);
      if (model_busy && !inst_valid) gaps++;
      cyc();
    end
    chk("t2_gaps", 32'(gaps), 32'd0);
    chk("t2_done", {31'd0, model_busy}, 32'd0);

    // Redirect while the read of 0x0013 is inflight.
    for (int i = 0; i < 8; i++) mem[16'h10 + i] = {OP_NULL, 11'(i + 16)};
    mem[16'h18] = {OP_END, 11'h2};
    for (int i = 0; i < 3; i++) mem[16'h05 + i] = {OP_NULL, 11'(i + 32)};
    mem[16'h08] = {OP_END, 11'h3};
    issue_start(16'h0010);
    seen13 = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c == 4) issue_redirect(16'h0005);
      @(negedge clk);
      if (c == 4) chk("t3_redir_addr", {16'd0, sram_addr}, 32'h5);
      if (c == 5) begin
        chk("t3_vld", {31'd0, inst_valid}, 32'd1);
        chk("t3_pc", {16'd0, inst_pc}, 32'h5);
      end
`ifdef IFETCH_PERF_EN
      if (c == 8) chk("t3_perf", perf_stall_cnt, 32'd0);
`endif
      if (c >= 4 && inst_valid && inst_pc == 16'h13) seen13 = 1'b1;
      cyc();
    end
    chk("t3_no_0013", {31'd0, seen13}, 32'd0);
    chk("t3_done", {31'd0, model_busy}, 32'd0);

    // PC wrap.
    mem[16'hFFFE] = {OP_NULL, 11'h10};
    mem[16'hFFFF] = {OP_NULL, 11'h11};
    mem[16'h0000] = {OP_NULL, 11'h12};
    mem[16'h0001] = {OP_END, 11'h13};
    issue_start(16'hFFFE);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 3) chk("t4_wrap_pc", {16'd0, inst_pc}, {16'd0, wrap_pc[c-1]});
      cyc();
    end
    chk("t4_done", {31'd0, model_busy}, 32'd0);

    // Reset with a read inflight, then a clean restart.
    issue_start(16'h0010);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cyc();
    end
    rst = 1'b1;
    exp_q.delete();
    model_busy = 1'b0;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("t5_sram_en", {31'd0, sram_en}, 32'd0);
    chk("t5_sram_addr", {16'd0, sram_addr}, 32'd0);
    chk("t5_inst", {16'd0, inst}, 32'd0);
    chk("t5_inst_pc", {16'd0, inst_pc}, 32'd0);
    chk("t5_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    cyc();
    repeat (3) begin
      @(negedge clk);
      cyc();
    end
    issue_start(16'h0005);
    @(negedge clk);
    cyc();
    wait_done(100, 100, 0, 16'h0005, 3);
    chk("t5_restart_done", {31'd0, model_busy}, 32'd0);

    // Randomised programs, ready patterns and redirects.
    for (int p = 0; p < 40; p++) begin
      base = 16'($urandom_range(16'h0100, 16'hFF00));
      len  = $urandom_range(0, 10);
      load_prog(base, len);
      inst_ready = $urandom_range(0, 1) == 1;
      issue_start(base);
      @(negedge clk);
      cyc();
      wait_done(400, $urandom_range(30, 100), 6, base, len);
      chk("rand_done", {31'd0, model_busy}, 32'd0);
      chk("rand_q_empty", 32'(exp_q.size()), 32'd0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        cyc();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
